// File: rtl/arm_bus_pkg.sv
// Shared constants for the ARM data-side bus: address map and UART transmitter states.
package arm_bus_pkg;

    localparam logic [31:0] RAM_BASE       = 32'h0000_0800;
    localparam logic [31:0] RAM_END        = 32'h0000_0BFF;
    localparam logic [31:0] UART_DATA_ADDR = 32'h0000_0C00;
    localparam logic [31:0] UART_STAT_ADDR = 32'h0000_0C04;
    localparam logic [31:0] LED_ADDR       = 32'h0000_0C08;
    localparam logic [31:0] DIP_ADDR       = 32'h0000_0C0C;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    function automatic logic is_ram_addr(input logic [31:0] addr);
        return (addr >= RAM_BASE) && (addr <= RAM_END);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 LSB-first serial transmitter; each bit lasts CLKS_PER_BIT cycles.
module uart_tx_fifo
    import arm_bus_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       push,
    input  logic [7:0] din,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       tx
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;

    uart_state_e   state;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;

    logic baud_end;
    logic pop;
    logic push_ok;

    // push is a one-cycle valid strobe and !full is its ready; a push seen
    // while not ready is dropped, except when a pop frees the slot on that same edge.
    assign full     = (count == (AW+1)'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign busy     = (state != IDLE);
    assign baud_end = (baud_cnt == BAUD_LAST);
    assign pop      = !empty && ((state == IDLE) || ((state == STOP) && baud_end));
    assign push_ok  = push && (!full || pop);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    // tx is updated on the same edge as the state change, so the line
    // tracks the state with identical timing for every bit of the frame.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    tx       <= 1'b1;
                    if (pop) begin
                        shift <= mem[rd_ptr];
                        state <= START;
                        tx    <= 1'b0;
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= DATA;
                        tx       <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        // A queued byte starts its START bit right after the stop bit.
                        if (pop) begin
                            shift <= mem[rd_ptr];
                            state <= START;
                            tx    <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/arm_data_bus.sv
// Data-side bus behind the single-cycle ARM core: data RAM, UART TX, LED register, DIP port.
module arm_data_bus
    import arm_bus_pkg::*;
#(
    parameter int RAM_DEPTH    = 128,
    parameter int FIFO_DEPTH   = 4,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        MemWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    input  logic [15:0] DIP,
    output logic [15:0] LED,
    output logic        UART_TX
);

    localparam int RAW = $clog2(RAM_DEPTH);

    logic [31:0]    addr;
    logic [RAW-1:0] ram_idx;
    logic           sel_ram;
    logic [31:0]    ram [RAM_DEPTH];
    logic [15:0]    dip_meta;
    logic [15:0]    dip_sync;
    logic           uart_push;
    logic           fifo_full;
    logic           fifo_empty;
    logic           tx_busy;

    // Byte offset within the word is ignored; only whole-word accesses exist.
    assign addr      = ALUResult & 32'hFFFF_FFFC;
    assign ram_idx   = addr[RAW+1:2];
    assign sel_ram   = is_ram_addr(addr);
    assign uart_push = MemWrite && (addr == UART_DATA_ADDR);

    always_ff @(posedge CLK) begin
        if (MemWrite && sel_ram) ram[ram_idx] <= WriteData;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            LED      <= '0;
            dip_meta <= '0;
            dip_sync <= '0;
        end else begin
            if (MemWrite && (addr == LED_ADDR)) LED <= WriteData[15:0];
            dip_meta <= DIP;
            dip_sync <= dip_meta;
        end
    end

    always_comb begin
        ReadData = '0;
        if (sel_ram) begin
            ReadData = ram[ram_idx];
        end else begin
            case (addr)
                UART_STAT_ADDR: ReadData = {29'b0, fifo_empty, fifo_full, tx_busy};
                LED_ADDR:       ReadData = {16'b0, LED};
                DIP_ADDR:       ReadData = {16'b0, dip_sync};
                default:        ReadData = '0;
            endcase
        end
    end

    uart_tx_fifo #(
        .FIFO_DEPTH   (FIFO_DEPTH),
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .push    (uart_push),
        .din     (WriteData[7:0]),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .busy    (tx_busy),
        .tx      (UART_TX)
    );

endmodule

// File: tb/tb_arm_data_bus.sv
// Directed bench for arm_data_bus with a fast UART (4 clocks per bit) and a 4-entry FIFO.
module tb_arm_data_bus;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] ALUResult = '0;
    logic [31:0] WriteData = '0;
    logic [31:0] ReadData;
    logic [15:0] DIP = '0;
    logic [15:0] LED;
    logic        UART_TX;

    int tests_run = 0;
    int tests_failed = 0;

    arm_data_bus #(
        .RAM_DEPTH    (128),
        .FIFO_DEPTH   (4),
        .CLKS_PER_BIT (4)
    ) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .MemWrite  (MemWrite),
        .ALUResult (ALUResult),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .DIP       (DIP),
        .LED       (LED),
        .UART_TX   (UART_TX)
    );

    // clock / watchdog
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic store(input logic [31:0] a, input logic [31:0] d);
        @(negedge CLK);
        ALUResult = a;
        WriteData = d;
        MemWrite  = 1'b1;
        @(negedge CLK);
        MemWrite  = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, output logic [31:0] d);
        MemWrite  = 1'b0;
        ALUResult = a;
        #1;
        d = ReadData;
    endtask

    // Expected line level per cycle for one 8N1 frame at 4 clocks per bit.
    function automatic logic [39:0] frame_bits(input logic [7:0] b);
        logic [39:0] f;
        f = '1;
        for (int j = 0; j < 4; j++) f[j] = 1'b0;
        for (int k = 0; k < 8; k++)
            for (int r = 0; r < 4; r++) f[4 + 4*k + r] = b[k];
        return f;
    endfunction

    task automatic test_reset();
        logic [31:0] rd;
        logic        saw_low;
        repeat (2) @(negedge CLK);
        tests_run++;
        if (LED !== 16'h0000) begin
            tests_failed++;
            $display("FAIL por_led: got %h expected %h", LED, 16'h0000);
        end
        tests_run++;
        if (UART_TX !== 1'b1) begin
            tests_failed++;
            $display("FAIL por_tx: got %b expected 1", UART_TX);
        end
        RESET_N = 1'b1;
        load(32'hC04, rd);
        tests_run++;
        if (rd !== 32'h4) begin
            tests_failed++;
            $display("FAIL por_stat: got %h expected %h", rd, 32'h4);
        end

        store(32'hC08, 32'h0000_BEEF);
        store(32'hC00, 32'h0000_00A5);
        repeat (10) @(negedge CLK);
        tests_run++;
        if (UART_TX !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_frame_bit1: got %b expected 0", UART_TX);
        end
        RESET_N = 1'b0;
        #1;
        tests_run++;
        if (UART_TX !== 1'b1) begin
            tests_failed++;
            $display("FAIL async_reset_tx: got %b expected 1", UART_TX);
        end
        tests_run++;
        if (LED !== 16'h0000) begin
            tests_failed++;
            $display("FAIL async_reset_led: got %h expected %h", LED, 16'h0000);
        end
        @(negedge CLK);
        RESET_N = 1'b1;
        load(32'hC04, rd);
        tests_run++;
        if (rd !== 32'h4) begin
            tests_failed++;
            $display("FAIL reset_stat: got %h expected %h", rd, 32'h4);
        end
        saw_low = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            if (UART_TX !== 1'b1) saw_low = 1'b1;
        end
        tests_run++;
        if (saw_low !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_frame_lost: got line_low=%b expected 0", saw_low);
        end
    endtask

    task automatic test_ram();
        logic [31:0] rd;
        store(32'h800, 32'h1111_1111);
        store(32'h804, 32'hDEAD_BEEF);
        load(32'h804, rd);
        tests_run++;
        if (rd !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL ram_804: got %h expected %h", rd, 32'hDEAD_BEEF);
        end
        load(32'h806, rd);
        tests_run++;
        if (rd !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL ram_byte_offset: got %h expected %h", rd, 32'hDEAD_BEEF);
        end
        load(32'h800, rd);
        tests_run++;
        if (rd !== 32'h1111_1111) begin
            tests_failed++;
            $display("FAIL ram_800: got %h expected %h", rd, 32'h1111_1111);
        end
        store(32'h1000, 32'h0000_FFFF);
        tests_run++;
        if (LED !== 16'h0000) begin
            tests_failed++;
            $display("FAIL unmapped_led: got %h expected %h", LED, 16'h0000);
        end
        load(32'h1000, rd);
        tests_run++;
        if (rd !== 32'h0) begin
            tests_failed++;
            $display("FAIL unmapped_read: got %h expected %h", rd, 32'h0);
        end
        load(32'h800, rd);
        tests_run++;
        if (rd !== 32'h1111_1111) begin
            tests_failed++;
            $display("FAIL unmapped_no_alias: got %h expected %h", rd, 32'h1111_1111);
        end
    endtask

    task automatic test_led_dip();
        logic [31:0] rd;
        store(32'hC08, 32'h0001_A5A5);
        tests_run++;
        if (LED !== 16'hA5A5) begin
            tests_failed++;
            $display("FAIL led_port: got %h expected %h", LED, 16'hA5A5);
        end
        load(32'hC08, rd);
        tests_run++;
        if (rd !== 32'h0000_A5A5) begin
            tests_failed++;
            $display("FAIL led_read: got %h expected %h", rd, 32'h0000_A5A5);
        end
        @(negedge CLK);
        DIP = 16'h1234;
        @(posedge CLK);
        #1;
        load(32'hC0C, rd);
        tests_run++;
        if (rd !== 32'h0) begin
            tests_failed++;
            $display("FAIL dip_edge1: got %h expected %h", rd, 32'h0);
        end
        @(posedge CLK);
        @(posedge CLK);
        #1;
        load(32'hC0C, rd);
        tests_run++;
        if (rd !== 32'h0000_1234) begin
            tests_failed++;
            $display("FAIL dip_edge3: got %h expected %h", rd, 32'h0000_1234);
        end
        store(32'hC0C, 32'hFFFF_FFFF);
        store(32'hC04, 32'hFFFF_FFFF);
        load(32'hC0C, rd);
        tests_run++;
        if (rd !== 32'h0000_1234) begin
            tests_failed++;
            $display("FAIL dip_write_ignored: got %h expected %h", rd, 32'h0000_1234);
        end
        load(32'hC04, rd);
        tests_run++;
        if (rd !== 32'h4) begin
            tests_failed++;
            $display("FAIL stat_write_ignored: got %h expected %h", rd, 32'h4);
        end
    endtask

    task automatic test_single_frame();
        logic [31:0] rd;
        logic [39:0] tx_obs;
        logic [39:0] busy_obs;
        store(32'hC00, 32'h0000_0055);
        load(32'hC04, rd);
        tests_run++;
        if (rd !== 32'h0) begin
            tests_failed++;
            $display("FAIL frame_stat_queued: got %h expected %h", rd, 32'h0);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            #1;
            tx_obs[i]   = UART_TX;
            busy_obs[i] = ReadData[0];
        end
        tests_run++;
        if (tx_obs !== frame_bits(8'h55)) begin
            tests_failed++;
            $display("FAIL frame_55_line: got %h expected %h", tx_obs, frame_bits(8'h55));
        end
        tests_run++;
        if (busy_obs !== {40{1'b1}}) begin
            tests_failed++;
            $display("FAIL frame_55_busy: got %h expected %h", busy_obs, {40{1'b1}});
        end
        @(negedge CLK);
        #1;
        tests_run++;
        if ({ReadData, UART_TX} !== {32'h4, 1'b1}) begin
            tests_failed++;
            $display("FAIL frame_55_end: got stat=%h tx=%b expected stat=4 tx=1", ReadData, UART_TX);
        end
    endtask

    task automatic test_fifo_full();
        logic [31:0]  rd;
        logic [199:0] line_bits;
        int           n;
        n = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge CLK);
            if (i >= 2) begin
                line_bits[n] = UART_TX;
                n++;
            end
            if (i < 6) begin
                ALUResult = 32'hC00;
                WriteData = 32'h41 + 32'(i);
                MemWrite  = 1'b1;
            end else begin
                MemWrite  = 1'b0;
            end
        end
        load(32'hC04, rd);
        tests_run++;
        if (rd !== 32'h3) begin
            tests_failed++;
            $display("FAIL fifo_full_stat: got %h expected %h", rd, 32'h3);
        end
        while (n < 200) begin
            @(negedge CLK);
            line_bits[n] = UART_TX;
            n++;
        end
        for (int k = 0; k < 5; k++) begin
            tests_run++;
            if (line_bits[40*k +: 40] !== frame_bits(8'h41 + 8'(k))) begin
                tests_failed++;
                $display("FAIL fifo_frame%0d: got %h expected %h", k, line_bits[40*k +: 40],
                         frame_bits(8'h41 + 8'(k)));
            end
        end
        @(negedge CLK);
        #1;
        tests_run++;
        if ({ReadData, UART_TX} !== {32'h4, 1'b1}) begin
            tests_failed++;
            $display("FAIL fifo_drained: got stat=%h tx=%b expected stat=4 tx=1", ReadData, UART_TX);
        end
    endtask

    task automatic test_push_pop_collision();
        logic [31:0]  rd;
        logic [199:0] line_bits;
        int           n;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (i < 5) begin
                ALUResult = 32'hC00;
                WriteData = 32'h61 + 32'(i);
                MemWrite  = 1'b1;
            end else begin
                MemWrite  = 1'b0;
            end
        end
        repeat (36) @(negedge CLK);
        load(32'hC04, rd);
        tests_run++;
        if (rd !== 32'h3) begin
            tests_failed++;
            $display("FAIL collide_pre_stat: got %h expected %h", rd, 32'h3);
        end
        ALUResult = 32'hC00;
        WriteData = 32'h66;
        MemWrite  = 1'b1;
        @(negedge CLK);
        load(32'hC04, rd);
        tests_run++;
        if (rd !== 32'h3) begin
            tests_failed++;
            $display("FAIL collide_post_stat: got %h expected %h", rd, 32'h3);
        end
        line_bits[0] = UART_TX;
        n = 1;
        while (n < 200) begin
            @(negedge CLK);
            line_bits[n] = UART_TX;
            n++;
        end
        for (int k = 0; k < 5; k++) begin
            tests_run++;
            if (line_bits[40*k +: 40] !== frame_bits(8'h62 + 8'(k))) begin
                tests_failed++;
                $display("FAIL collide_frame%0d: got %h expected %h", k, line_bits[40*k +: 40],
                         frame_bits(8'h62 + 8'(k)));
            end
        end
        @(negedge CLK);
        #1;
        tests_run++;
        if ({ReadData, UART_TX} !== {32'h4, 1'b1}) begin
            tests_failed++;
            $display("FAIL collide_drained: got stat=%h tx=%b expected stat=4 tx=1", ReadData, UART_TX);
        end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_led_dip();
        test_single_frame();
        test_fifo_full();
        test_push_pop_collision();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
